// File: rtl/o232c_buffered_pkg.sv
// Shared definitions for the buffered 8N1 transmitter: FSM state encoding and default timing.
package o232c_buffered_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // 71.4 MHz system clock at 115200 baud.
  localparam int DEFAULT_WAIT_DIV = 620;
  localparam int DEFAULT_FIFO_LOG = 4;

endpackage

// File: rtl/o232c_buffered_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the head entry is always visible on rd_data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << LOG;

  logic [LOG:0]     wr_ptr;
  logic [LOG:0]     rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Equal pointers mean empty; equal index with differing lap bit means full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LOG] != rd_ptr[LOG]) && (wr_ptr[LOG-1:0] == rd_ptr[LOG-1:0]);
  assign rd_data = mem[rd_ptr[LOG-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (LOG+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (LOG+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[LOG-1:0]] <= wr_data;
  end

endmodule

// File: rtl/o232c_buffered.sv
// Buffered 8N1 RS-232 transmitter: bytes queue in a FIFO and are sent LSB-first at WAIT_DIV clocks per bit.
module o232c_buffered
  import o232c_buffered_pkg::*;
#(
  parameter int WAIT_DIV = DEFAULT_WAIT_DIV,
  parameter int FIFO_LOG = DEFAULT_FIFO_LOG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int                BAUD_W    = (WAIT_DIV > 1) ? $clog2(WAIT_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(WAIT_DIV - 1);

  state_t            state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_cnt, bit_next;
  logic [7:0]        shreg, shreg_next;
  logic              pop, push, empty, baud_done;
  logic [7:0]        head;

  // A write into a full FIFO still lands when the FSM frees a slot in the same cycle.
  assign push      = enable && (!full || pop);
  assign baud_done = (baud_cnt == BAUD_LAST);

  sync_fifo #(
    .WIDTH (8),
    .LOG   (FIFO_LOG)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + BAUD_W'(1);
    bit_next   = bit_cnt;
    shreg_next = shreg;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (!empty) begin
          pop        = 1'b1;
          shreg_next = head;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = '0;
          shreg_next = {1'b0, shreg[7:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (baud_done) begin
          baud_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            shreg_next = head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line and status registers follow the current state, so they trail it by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shreg[0];
        default: tx <= 1'b1;
      endcase
      busy <= (state != IDLE) || !empty;
      if (enable && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_o232c_buffered.sv
// Directed plus randomized bench for o232c_buffered against a queue/timer reference model and a line decoder.
module tb_o232c_buffered;

  localparam int W     = 4;
  localparam int L     = 2;
  localparam int DEPTH = 1 << L;
  localparam int FRAME = 10 * W;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] data;
  logic       full;
  logic       busy;
  logic       overflow;
  logic       tx;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: FIFO contents as a queue plus the remaining length of the frame on the line.
  logic [7:0] m_q[$];
  logic [7:0] exp_sent[$];
  int         m_timer = 0;
  logic [7:0] m_cur   = 8'h00;
  logic       m_ovf   = 1'b0;
  logic       exp_tx, exp_busy, exp_full;

  // Line decoder state and logs.
  int         d_cnt = -1;
  logic [7:0] d_byte;
  logic [7:0] dec_q[$];
  logic [7:0] want_q[$];
  int         falls[$];
  bit         t6_active = 1'b0;

  o232c_buffered #(
    .WAIT_DIV (W),
    .FIFO_LOG (L)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .data     (data),
    .full     (full),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%02h expected=%02h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [7:0] d);
    bit pop, accept;
    int bitn;
    if (rst) begin
      m_q.delete();
      exp_sent.delete();
      m_timer  = 0;
      m_ovf    = 1'b0;
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      exp_full = 1'b0;
      return;
    end
    if (m_timer == 0) exp_tx = 1'b1;
    else begin
      bitn = (FRAME - m_timer) / W;
      if (bitn == 0)      exp_tx = 1'b0;
      else if (bitn == 9) exp_tx = 1'b1;
      else                exp_tx = m_cur[bitn-1];
    end
    exp_busy = (m_timer != 0) || (m_q.size() != 0);
    pop    = (m_q.size() != 0) && (m_timer <= 1);
    accept = en && ((m_q.size() < DEPTH) || pop);
    if (en && !accept) m_ovf = 1'b1;
    if (m_timer > 0) m_timer--;
    if (pop) begin
      m_cur   = m_q.pop_front();
      exp_sent.push_back(m_cur);
      m_timer = FRAME;
    end
    if (accept) m_q.push_back(d);
    exp_full = (m_q.size() == DEPTH);
  endtask

  task automatic decode_step(input logic rst);
    int k;
    if (rst) begin
      d_cnt = -1;
      return;
    end
    if (d_cnt < 0) begin
      if (tx === 1'b0) begin
        d_cnt = 0;
        falls.push_back(cycle);
      end
      return;
    end
    d_cnt++;
    if ((d_cnt % W) != (W / 2)) return;
    k = d_cnt / W;
    if (k == 0) check_bit("dec_start_bit", tx, 1'b0);
    else if (k <= 8) d_byte[k-1] = tx;
    else begin
      check_bit("dec_stop_bit", tx, 1'b1);
      dec_q.push_back(d_byte);
      check_int("dec_byte_expected", (exp_sent.size() > 0) ? 1 : 0, 1);
      if (exp_sent.size() > 0) check_byte("dec_byte", d_byte, exp_sent.pop_front());
      d_cnt = -1;
    end
  endtask

  task automatic check_output();
    check_bit("cyc_tx", tx, exp_tx);
    check_bit("cyc_busy", busy, exp_busy);
    check_bit("cyc_full", full, exp_full);
    check_bit("cyc_overflow", overflow, m_ovf);
    if (t6_active) check_bit("t6_full_never", full, 1'b0);
  endtask

  // One clock: drive inputs, step the model at the edge, check and decode at the following negedge.
  task automatic apply_stimulus(input logic rst, input logic en, input logic [7:0] d);
    reset  = rst;
    enable = en;
    data   = d;
    @(posedge clk);
    model_step(rst, en, d);
    @(negedge clk);
    cycle++;
    check_output();
    decode_step(rst);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    idle(2);
    while (busy !== 1'b0 && n < budget) begin
      apply_stimulus(1'b0, 1'b0, 8'h00);
      n++;
    end
    check_int({tag, "_idle_timeout"}, (n < budget) ? 1 : 0, 1);
    idle(2);
  endtask

  task automatic check_decoded(input string tag);
    check_int({tag, "_dec_count"}, dec_q.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < dec_q.size(); i++)
      check_byte({tag, "_dec_order"}, dec_q[i], want_q[i]);
  endtask

  initial begin
    logic [9:0] t1_bits;
    logic [7:0] b;
    int         c0;
    int         n;

    reset  = 1'b1;
    enable = 1'b0;
    data   = 8'h00;
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_bit("reset_tx", tx, 1'b1);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_full", full, 1'b0);
    check_bit("reset_overflow", overflow, 1'b0);

    // Single byte: latency, bit pattern, busy release.
    dec_q.delete();
    apply_stimulus(1'b0, 1'b1, 8'h41);
    c0 = cycle;
    idle(1);
    check_bit("t1_tx_edge_n1", tx, 1'b1);
    idle(1);
    check_bit("t1_tx_edge_n2", tx, 1'b0);
    t1_bits = 10'b1010000010;
    idle(W / 2);
    check_bit("t1_bit", tx, t1_bits[0]);
    for (int k = 1; k < 10; k++) begin
      idle(W);
      check_bit("t1_bit", tx, t1_bits[k]);
    end
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      idle(1);
      n++;
    end
    check_int("t1_busy_fall_delay", cycle - (c0 + 2), 40);
    want_q = '{8'h41};
    idle(2);
    check_decoded("t1");

    // Three back-to-back frames.
    dec_q.delete();
    falls.delete();
    apply_stimulus(1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'hFF);
    apply_stimulus(1'b0, 1'b1, 8'h55);
    wait_idle("t2", 300);
    check_int("t2_start_count", falls.size(), 3);
    if (falls.size() >= 3) begin
      check_int("t2_gap_1_2", falls[1] - falls[0], 40);
      check_int("t2_gap_2_3", falls[2] - falls[1], 40);
    end
    want_q = '{8'h00, 8'hFF, 8'h55};
    check_decoded("t2");

    // Overfill a depth-4 FIFO.
    dec_q.delete();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'h10 + 8'(i));
      if (i == 3) check_bit("t3_full_after4", full, 1'b0);
      if (i == 4) check_bit("t3_full_after5", full, 1'b1);
    end
    check_bit("t3_overflow", overflow, 1'b1);
    wait_idle("t3", 400);
    want_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_decoded("t3");

    // Write while full in the exact cycle the FSM pops.
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_bit("t4_overflow_cleared", overflow, 1'b0);
    dec_q.delete();
    want_q.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      want_q.push_back(b);
      apply_stimulus(1'b0, 1'b1, b);
    end
    check_bit("t4_full_held", full, 1'b1);
    n = 0;
    while (m_timer != 1 && n < 100) begin
      idle(1);
      n++;
    end
    check_int("t4_pop_wait_timeout", (n < 100) ? 1 : 0, 1);
    apply_stimulus(1'b0, 1'b1, 8'hAA);
    want_q.push_back(8'hAA);
    check_bit("t4_overflow_unchanged", overflow, 1'b0);
    check_bit("t4_still_full", full, 1'b1);
    wait_idle("t4", 600);
    check_decoded("t4");

    // Reset during DATA bit 3 with two bytes queued.
    apply_stimulus(1'b0, 1'b1, 8'hC3);
    apply_stimulus(1'b0, 1'b1, 8'($urandom));
    apply_stimulus(1'b0, 1'b1, 8'($urandom));
    idle(15);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_bit("t5_tx", tx, 1'b1);
    check_bit("t5_busy", busy, 1'b0);
    check_bit("t5_full", full, 1'b0);
    check_bit("t5_overflow", overflow, 1'b0);
    dec_q.delete();
    idle(100);
    check_int("t5_no_bytes", dec_q.size(), 0);
    check_bit("t5_line_high", tx, 1'b1);

    // Pointer wrap: 20 bytes, one write per frame.
    dec_q.delete();
    want_q.delete();
    t6_active = 1'b1;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'(i));
      want_q.push_back(8'(i));
      wait_idle("t6", 200);
    end
    t6_active = 1'b0;
    check_decoded("t6");

    // Random bursts checked cycle by cycle against the model.
    apply_stimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 600; i++)
      apply_stimulus(1'b0, ($urandom_range(0, 2) == 0), 8'($urandom));
    wait_idle("t7", 1000);
    check_int("t7_all_delivered", exp_sent.size(), 0);
    check_int("t7_fifo_drained", m_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
